// File: rtl/dsp_mix_sched.sv
// dsp_mix_sched: time-multiplexed saturating mixer.
// One shared clamped adder sums NCH voice channels, one channel per clock,
// into a single mixed sample per sample tick.
//
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   sample_tick  - one-cycle strobe starting a mix cycle
//   ch_in        - packed signed samples, channel k at [k*`BITS +: `BITS]
//   ch_en        - per-channel enable (0 mutes the channel)
//   mix_out      - signed mixed sample, held between updates
//   mix_valid    - one-cycle pulse when mix_out updates
//   busy         - high while a mix cycle is in progress
//   overrun      - sticky: sample_tick arrived while busy
//   overrun_clr  - clears overrun (an overrun event in the same cycle wins)

`ifndef BITS
`define BITS 16
`endif
`ifndef FPWIDTH
`define FPWIDTH 15
`endif

module dsp_mix_sched #(
  parameter int NCH = 4,
  parameter int CW  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_tick,
  input  logic [NCH*`BITS-1:0]   ch_in,
  input  logic [NCH-1:0]         ch_en,
  output logic [`BITS-1:0]       mix_out,
  output logic                   mix_valid,
  output logic                   busy,
  output logic                   overrun,
  input  logic                   overrun_clr
);

  localparam int W = `BITS;
  localparam logic signed [W:0]  CMAX = (W+1)'((2 ** `FPWIDTH) - 1);
  localparam logic signed [W:0]  CMIN = (W+1)'(-(2 ** `FPWIDTH));
  localparam logic [CW-1:0]      LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t              state, state_d;
  logic [NCH*W-1:0]    snap_q;
  logic [NCH-1:0]      en_q;
  logic [CW-1:0]       idx;
  logic signed [W-1:0] acc;
  logic signed [W-1:0] cur;
  logic signed [W:0]   sum;
  logic signed [W-1:0] acc_nxt;

  // The snapshot shifts down one channel per ACCUM cycle, so the channel
  // being added is always in the lowest slot; idx only counts steps.
  always_comb begin
    cur = en_q[0] ? $signed(snap_q[W-1:0]) : '0;
    sum = {acc[W-1], acc} + {cur[W-1], cur};
    if (sum > CMAX)
      acc_nxt = CMAX[W-1:0];
    else if (sum < CMIN)
      acc_nxt = CMIN[W-1:0];
    else
      acc_nxt = sum[W-1:0];
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (sample_tick) state_d = ACCUM;
      ACCUM:   if (idx == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign mix_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_d;
  end

  // mix_out is loaded on the final ACCUM step so it is already valid
  // during the DONE cycle that raises mix_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q  <= '0;
      en_q    <= '0;
      idx     <= '0;
      acc     <= '0;
      mix_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_tick) begin
            snap_q <= ch_in;
            en_q   <= ch_en;
            acc    <= '0;
            idx    <= '0;
          end
        end
        ACCUM: begin
          acc    <= acc_nxt;
          idx    <= idx + 1'b1;
          snap_q <= snap_q >> W;
          en_q   <= en_q >> 1;
          if (idx == LAST)
            mix_out <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overrun <= 1'b0;
    else if (sample_tick && (state != IDLE))
      overrun <= 1'b1;
    else if (overrun_clr)
      overrun <= 1'b0;
  end

endmodule

// File: tb/tb_dsp_mix_sched.sv
`ifndef BITS
`define BITS 16
`endif
`ifndef FPWIDTH
`define FPWIDTH 15
`endif

module tb_dsp_mix_sched;

  localparam int NCH  = 4;
  localparam int BW   = `BITS;
  localparam int CMAX = (2 ** `FPWIDTH) - 1;
  localparam int CMIN = -(2 ** `FPWIDTH);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                sample_tick = 1'b0;
  logic [NCH*BW-1:0]   ch_in = '0;
  logic [NCH-1:0]      ch_en = '0;
  logic [BW-1:0]       mix_out;
  logic                mix_valid;
  logic                busy;
  logic                overrun;
  logic                overrun_clr = 1'b0;

  dsp_mix_sched #(.NCH(NCH), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .ch_in(ch_in),
    .ch_en(ch_en), .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  typedef struct { int val; int cyc; } exp_t;
  exp_t sb[$];
  int   dq[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_t   = -100;
  bit m_ovr    = 1'b0;
  int m_mix    = 0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: sequential sum in channel order, clamped after every step.
  function automatic int mix_model(input logic [NCH*BW-1:0] d, input logic [NCH-1:0] e);
    int a = 0;
    for (int k = 0; k < NCH; k++) begin
      logic signed [BW-1:0] s;
      s = $signed(d[k*BW +: BW]);
      if (e[k]) a += int'(s);
      if (a > CMAX) a = CMAX;
      if (a < CMIN) a = CMIN;
    end
    return a;
  endfunction

  function automatic logic [NCH*BW-1:0] pk(input int a, input int b, input int c, input int d);
    return {d[BW-1:0], c[BW-1:0], b[BW-1:0], a[BW-1:0]};
  endfunction

  function automatic logic [BW-1:0] rand_sample();
    int r;
    r = $urandom_range(0, 4);
    case (r)
      0: return BW'(CMAX);
      1: return BW'(CMIN);
      2: return BW'($urandom_range(0, 200) - 100);
      default: return BW'($urandom);
    endcase
  endfunction

  function automatic logic [NCH*BW-1:0] rand_vec();
    logic [NCH*BW-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*BW +: BW] = rand_sample();
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Timing model: a tick accepted in period T keeps the mixer busy for
  // periods T+1..T+NCH+1 and delivers its result in period T+NCH+1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_t = -100;
      m_ovr  = 1'b0;
    end else begin
      if (sample_tick) begin
        if (cyc <= last_t + NCH + 1) begin
          m_ovr = 1'b1;
        end else begin
          last_t = cyc;
          sb.push_back('{mix_model(ch_in, ch_en), cyc + NCH + 1});
          if (overrun_clr) m_ovr = 1'b0;
        end
      end else if (overrun_clr) begin
        m_ovr = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    bit   exp_busy;
    if (!rst_n) begin
      sb.delete();
      m_mix = 0;
      check(mix_out == '0 && !mix_valid && !busy && !overrun, "reset_outputs",
            int'({mix_valid, busy, overrun}), 0);
    end else begin
      exp_busy = (cyc >= last_t + 1) && (cyc <= last_t + NCH + 1);
      check(busy == exp_busy, "busy", int'(busy), int'(exp_busy));
      check(overrun == m_ovr, "overrun", int'(overrun), int'(m_ovr));
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        check(1'b0, "missed_valid", 0, e.cyc);
      end
      if (mix_valid) begin
        if (sb.size() == 0) begin
          check(1'b0, "spurious_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check(cyc == e.cyc, "latency", cyc, e.cyc);
          check(int'($signed(mix_out)) == e.val, "mix_value", int'($signed(mix_out)), e.val);
          m_mix = e.val;
          if (dq.size() > 0) begin
            int c;
            c = dq.pop_front();
            check(int'($signed(mix_out)) == c, "directed_value", int'($signed(mix_out)), c);
          end
        end
      end
      check(int'($signed(mix_out)) == m_mix, "mix_hold", int'($signed(mix_out)), m_mix);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Tick is high for one period; afterwards the inputs are scrambled so the
  // snapshot is what gets mixed.
  task automatic tick(input logic [NCH*BW-1:0] d, input logic [NCH-1:0] e, input logic clr = 1'b0);
    ch_in = d;
    ch_en = e;
    sample_tick = 1'b1;
    overrun_clr = clr;
    @(negedge clk);
    sample_tick = 1'b0;
    overrun_clr = 1'b0;
    ch_in = rand_vec();
    ch_en = NCH'($urandom);
  endtask

  initial begin
    logic [NCH-1:0] en_r;
    int gap;

    idle(3);
    #1 rst_n = 1'b1;
    idle(2);

    // Basic mix
    dq.push_back(257);
    tick(pk(100, 200, -50, 7), 4'b1111);
    idle(8);

    // Positive saturation
    dq.push_back(31767);
    tick(pk(30000, 30000, -1000, 0), 4'b1111);
    idle(8);

    // Negative saturation with channel 2 muted
    dq.push_back(-32759);
    tick(pk(-30000, -30000, 5, 9), 4'b1011);
    idle(8);

    // Order dependence: clamp after +max, +max then subtract
    dq.push_back(0);
    tick(pk(32767, 32767, -32767, 0), 4'b1111);
    idle(8);

    // Overrun: second tick three cycles later is ignored
    dq.push_back(10000);
    tick(pk(1000, 2000, 3000, 4000), 4'b1111);
    idle(2);
    tick(pk(5, 5, 5, 5), 4'b1111);
    idle(6);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    idle(3);

    // Overrun set and clear in the same cycle: set wins
    dq.push_back(-4);
    tick(pk(-1, -1, -1, -1), 4'b1111);
    idle(1);
    tick(pk(9, 9, 9, 9), 4'b1111, 1'b1);
    idle(6);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    idle(2);

    // Back-to-back at minimum spacing, inputs disturbed mid-mix
    dq.push_back(10);
    tick(pk(1, 2, 3, 4), 4'b1111);
    idle(1);
    ch_in = pk(999, 999, 999, 999);
    idle(4);
    dq.push_back(-20);
    tick(pk(-5, -5, -5, -5), 4'b1111);
    idle(8);

    // Reset mid-mix: no result, then normal operation
    tick(pk(7, 7, 7, 7), 4'b1111);
    #1 rst_n = 1'b0;
    idle(2);
    #1 rst_n = 1'b1;
    idle(2);
    dq.push_back(4);
    tick(pk(1, 1, 1, 1), 4'b1111);
    idle(8);

    // Randomized traffic including too-close ticks and random clears
    for (int i = 0; i < 150; i++) begin
      gap = $urandom_range(0, NCH + 4);
      repeat (gap) begin
        overrun_clr = ($urandom_range(0, 7) == 0);
        @(negedge clk);
      end
      overrun_clr = 1'b0;
      en_r = NCH'($urandom);
      tick(rand_vec(), en_r, ($urandom_range(0, 9) == 0));
    end

    idle(NCH + 4);
    check(sb.size() == 0, "drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
